sine_table_writer: RTL

SINE_TABLE_WRITER -- requirements
Module: sine_table_writer

---
 rtl/sine_table_writer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/sine_table_writer.sv
// Fills a 512-entry quarter-wave sine table, one rotation-mode CORDIC pass per entry.
// Define SINE_WRITER_READBACK_EN to add a readback sweep that flags any table corruption.
module sine_table_writer #(
  parameter int unsigned ENTRIES    = 512,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ITERS      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  wr_ready,
  output logic                  we,
  output logic [8:0]            waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done
`ifdef SINE_WRITER_READBACK_EN
  ,
  output logic [8:0]            raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  mismatch
`endif
);

  localparam int unsigned KW   = $clog2(ITERS);
  localparam int unsigned GB   = 4;        // guard bits below the output LSB
  localparam int unsigned XW   = 18 + GB;
  localparam int unsigned ZW   = 24;
  localparam int unsigned ZF   = 17 + GB;  // angle unit is 2^-17 rad with GB extra fraction bits
  localparam int unsigned ResW = 10;
  localparam int          YMax = (1 << DATA_WIDTH) - 1;

  localparam logic [8:0]           LastIdx = 9'(ENTRIES - 1);
  localparam logic signed [XW-1:0] X0      = XW'(39797 << GB);

`ifdef SINE_WRITER_READBACK_EN
  typedef enum logic [2:0] {StIdle, StLoad, StIter, StWrite, StVerify, StFinish} state_e;
  localparam logic [9:0] VerifyLast = 10'(ENTRIES + 1);
`else
  typedef enum logic [2:0] {StIdle, StLoad, StIter, StWrite, StFinish} state_e;
`endif

  state_e               state_q;
  logic [8:0]           idx_q;
  logic [KW-1:0]        k_q;
  logic signed [XW-1:0] x_q, y_q, x_n, y_n, x_sh, y_sh;
  logic signed [ZW-1:0] z_q, z_n, z0, atan_k;
  logic [29:0]          z_prod;
  logic signed [31:0]   x_ext, z_ext, prod, y_ext, y_corr, y_trim, y_rnd;
  logic [DATA_WIDTH-1:0] y_sat;

  function automatic logic signed [ZW-1:0] atan_lut(input logic [KW-1:0] k);
    logic signed [ZW-1:0] v;
    case (int'(k))
      0:       v = ZW'(1647099);
      1:       v = ZW'(972340);
      2:       v = ZW'(513757);
      3:       v = ZW'(260791);
      4:       v = ZW'(130902);
      5:       v = ZW'(65515);
      6:       v = ZW'(32765);
      7:       v = ZW'(16384);
      8:       v = ZW'(8192);
      9:       v = ZW'(4096);
      10:      v = ZW'(2048);
      11:      v = ZW'(1024);
      12:      v = ZW'(512);
      13:      v = ZW'(256);
      14:      v = ZW'(128);
      15:      v = ZW'(64);
      default: v = '0;
    endcase
    return v;
  endfunction

  always_comb begin
    // Angle of entry i is (2i+1)*pi*1024 in 2^-21 rad; constant carries 8 more fraction bits.
    z_prod = 30'({idx_q, 1'b1}) * 30'd823550;
    z0     = ZW'((z_prod + 30'd128) >> 8);
    atan_k = atan_lut(k_q);
    x_sh   = x_q >>> k_q;
    y_sh   = y_q >>> k_q;
    if (!z_q[ZW-1]) begin
      x_n = x_q - y_sh;
      y_n = y_q + x_sh;
      z_n = z_q - atan_k;
    end else begin
      x_n = x_q + y_sh;
      y_n = y_q - x_sh;
      z_n = z_q + atan_k;
    end
    // Rotate the leftover residual angle in by small-angle approximation, then trim the
    // 2^16 full scale set by x0 down to 65535 and round off the guard bits.
    x_ext  = {{(32 - XW){x_n[XW-1]}}, x_n};
    z_ext  = {{(32 - ResW){z_n[ResW-1]}}, z_n[ResW-1:0]};
    prod   = x_ext * z_ext;
    y_ext  = {{(32 - XW){y_n[XW-1]}}, y_n};
    y_corr = y_ext + (prod >>> ZF);
    y_trim = y_corr - (y_corr >>> 16);
    y_rnd  = (y_trim + 32'sd8) >>> GB;
    if (y_rnd < 0) begin
      y_sat = '0;
    end else if (y_rnd > YMax) begin
      y_sat = '1;
    end else begin
      y_sat = y_rnd[DATA_WIDTH-1:0];
    end
  end

`ifdef SINE_WRITER_READBACK_EN
  logic [DATA_WIDTH-1:0] shadow_mem [ENTRIES];
  logic [DATA_WIDTH-1:0] exp1_q, exp2_q;
  logic [9:0]            vcnt_q;

  // Mirrors every write the RAM accepts.
  always_ff @(posedge clk) begin
    if (we && wr_ready) shadow_mem[waddr] <= wdata;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      k_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SINE_WRITER_READBACK_EN
      raddr    <= '0;
      mismatch <= 1'b0;
      vcnt_q   <= '0;
      exp1_q   <= '0;
      exp2_q   <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLoad;
            idx_q   <= '0;
            busy    <= 1'b1;
`ifdef SINE_WRITER_READBACK_EN
            mismatch <= 1'b0;
`endif
          end
        end
        StLoad: begin
          x_q     <= X0;
          y_q     <= '0;
          z_q     <= z0;
          k_q     <= '0;
          state_q <= StIter;
        end
        StIter: begin
          x_q <= x_n;
          y_q <= y_n;
          z_q <= z_n;
          k_q <= k_q + 1'b1;
          if (k_q == KW'(ITERS - 1)) begin
            state_q <= StWrite;
            we      <= 1'b1;
            waddr   <= idx_q;
            wdata   <= y_sat;
          end
        end
        StWrite: begin
          if (wr_ready) begin
            we <= 1'b0;
            if (idx_q == LastIdx) begin
`ifdef SINE_WRITER_READBACK_EN
              state_q <= StVerify;
              raddr   <= '0;
              vcnt_q  <= '0;
`else
              state_q <= StFinish;
              done    <= 1'b1;
`endif
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= StLoad;
            end
          end
        end
`ifdef SINE_WRITER_READBACK_EN
        StVerify: begin
          // rdata returns two cycles after raddr, so the expected word rides a matching pipe.
          vcnt_q <= vcnt_q + 1'b1;
          if (raddr != LastIdx) raddr <= raddr + 1'b1;
          exp1_q <= shadow_mem[raddr];
          exp2_q <= exp1_q;
          if (vcnt_q >= 10'd2 && rdata != exp2_q) mismatch <= 1'b1;
          if (vcnt_q == VerifyLast) begin
            state_q <= StFinish;
            done    <= 1'b1;
          end
        end
`endif
        StFinish: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
